// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for rename/dispatch.
//   Dispatch pops up to N_WAY tags per cycle (in-order grants), ROB retirement
//   pushes each freed previous mapping (tag_old), and branch_haz rewinds the
//   speculative pop pointer to the retired (architectural) pop pointer.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   alloc_req            per-slot request for a new destination tag
//   alloc_tag            granted tag per slot (0 when not granted), slot k at [k*TAG_W +: TAG_W]
//   alloc_grant          per-slot grant
//   free_avail           min(count, N_WAY) from registered state
//   retire_valid         ROB retire strobes
//   retire_tag           retired destination tag (0 = no destination)
//   retire_told          previous mapping to free (0 = nothing to free)
//   branch_haz           flush: rewind head to the architectural position
//   error                sticky error flag, present only with FREELIST_ERR_EN
//
// Build option: define FREELIST_ERR_EN to add the error port and its checks.

module free_list #(
  parameter int unsigned N_WAY  = 2,
  parameter int unsigned N_PHYS = 64,
  parameter int unsigned N_ARCH = 32,
  parameter int unsigned TAG_W  = $clog2(N_PHYS),
  localparam int unsigned AVW   = $clog2(N_WAY) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_WAY-1:0]       alloc_req,
  output logic [N_WAY*TAG_W-1:0] alloc_tag,
  output logic [N_WAY-1:0]       alloc_grant,
  output logic [AVW-1:0]         free_avail,
  input  logic [N_WAY-1:0]       retire_valid,
  input  logic [N_WAY*TAG_W-1:0] retire_tag,
  input  logic [N_WAY*TAG_W-1:0] retire_told,
  input  logic                   branch_haz
`ifdef FREELIST_ERR_EN
  ,
  output logic                   error
`endif
);

  localparam int unsigned FREE_INIT = N_PHYS - N_ARCH;

  localparam logic [TAG_W:0] PtrOne    = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W:0] NWayPtr   = N_WAY[TAG_W:0];
  localparam logic [TAG_W:0] TailInit  = FREE_INIT[TAG_W:0];
  localparam logic [AVW-1:0] NWayAvail = N_WAY[AVW-1:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [TAG_W-1:0] r_mem [N_PHYS];
  logic [TAG_W:0]   r_head;
  logic [TAG_W:0]   r_tail;
  logic [TAG_W:0]   r_arch_head;

  logic [TAG_W:0]   w_count;
  logic [TAG_W:0]   w_n_grant;
  logic [TAG_W:0]   w_head_d;
  logic [TAG_W:0]   w_tail_d;
  logic [TAG_W:0]   w_arch_d;
  logic [N_WAY-1:0] w_push;
  logic [TAG_W:0]   w_push_ptr [N_WAY];

  assign w_count = r_tail - r_head;

  assign free_avail = (w_count >= NWayPtr) ? NWayAvail : w_count[AVW-1:0];

  // Slot k takes entry head+<number of lower requesting slots>; once one slot
  // runs out of capacity every higher requester does too, keeping grants in order.
  always_comb begin
    logic [TAG_W:0] lower;
    logic [TAG_W:0] ptr;
    lower       = '0;
    ptr         = '0;
    w_n_grant   = '0;
    alloc_grant = '0;
    alloc_tag   = '0;
    for (int k = 0; k < int'(N_WAY); k++) begin
      if (alloc_req[k]) begin
        if (!branch_haz && (lower < w_count)) begin
          ptr                           = r_head + lower;
          alloc_grant[k]                = 1'b1;
          alloc_tag[k*TAG_W +: TAG_W]   = r_mem[ptr[TAG_W-1:0]];
          w_n_grant                     = w_n_grant + PtrOne;
        end
        lower = lower + PtrOne;
      end
    end
  end

  // Retire slots are packed at tail in slot order; only non-zero told is freed.
  always_comb begin
    logic [TAG_W:0] n_push;
    logic [TAG_W:0] n_adv;
    n_push = '0;
    n_adv  = '0;
    for (int i = 0; i < int'(N_WAY); i++) begin
      w_push[i]     = retire_valid[i] && (retire_told[i*TAG_W +: TAG_W] != '0);
      w_push_ptr[i] = r_tail + n_push;
      if (w_push[i]) n_push = n_push + PtrOne;
      if (retire_valid[i] && (retire_tag[i*TAG_W +: TAG_W] != '0)) n_adv = n_adv + PtrOne;
    end
    w_tail_d = r_tail + n_push;
    w_arch_d = r_arch_head + n_adv;
    // Flush sees this cycle's retirements before rewinding.
    w_head_d = branch_haz ? w_arch_d : (r_head + w_n_grant);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_PHYS); i++) begin
        r_mem[i] <= (i < int'(FREE_INIT)) ? TAG_W'(int'(N_ARCH) + i) : '0;
      end
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= TailInit;
    end else begin
      for (int i = 0; i < int'(N_WAY); i++) begin
        if (w_push[i]) r_mem[w_push_ptr[i][TAG_W-1:0]] <= retire_told[i*TAG_W +: TAG_W];
      end
      r_head      <= w_head_d;
      r_tail      <= w_tail_d;
      r_arch_head <= w_arch_d;
    end
  end

`ifdef FREELIST_ERR_EN
  localparam logic [TAG_W:0] CapPtr  = FREE_INIT[TAG_W:0];
  localparam logic [TAG_W:0] NPhysPtr = N_PHYS[TAG_W:0];

  logic r_error;
  logic w_err_set;

  // A pushed tag >= N_PHYS cannot be expressed in TAG_W bits, so only overflow
  // and arch_head overtaking tail need checking here.
  always_comb begin
    w_err_set = 1'b0;
    for (int i = 0; i < int'(N_WAY); i++) begin
      if (w_push[i] && ((w_push_ptr[i] - r_head) >= CapPtr)) w_err_set = 1'b1;
    end
    // arch_head past tail makes the modular distance wrap to a large value.
    if ((w_tail_d - w_arch_d) > NPhysPtr) w_err_set = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if (w_err_set) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  localparam int N_WAY  = 2;
  localparam int N_PHYS = 64;
  localparam int N_ARCH = 32;
  localparam int TAG_W  = 6;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [N_WAY-1:0]       alloc_req = '0;
  logic [N_WAY*TAG_W-1:0] alloc_tag;
  logic [N_WAY-1:0]       alloc_grant;
  logic [1:0]             free_avail;
  logic [N_WAY-1:0]       retire_valid = '0;
  logic [N_WAY*TAG_W-1:0] retire_tag = '0;
  logic [N_WAY*TAG_W-1:0] retire_told = '0;
  logic                   branch_haz = 1'b0;
`ifdef FREELIST_ERR_EN
  logic                   error;
`endif

  always #5 clock = ~clock;

  free_list #(
    .N_WAY (N_WAY),
    .N_PHYS(N_PHYS),
    .N_ARCH(N_ARCH),
    .TAG_W (TAG_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_tag   (alloc_tag),
    .alloc_grant (alloc_grant),
    .free_avail  (free_avail),
    .retire_valid(retire_valid),
    .retire_tag  (retire_tag),
    .retire_told (retire_told),
    .branch_haz  (branch_haz)
`ifdef FREELIST_ERR_EN
    ,
    .error       (error)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every tag ever made free, in order, indexed by unbounded positions.
  int hist[$];
  int spec_pos;
  int arch_pos;
  int owned[$];   // tags handed out and not yet freed
  bit chk_en = 1'b0;

  task automatic model_reset();
    hist.delete();
    owned.delete();
    for (int i = 0; i < N_PHYS - N_ARCH; i++) hist.push_back(N_ARCH + i);
    spec_pos = 0;
    arch_pos = 0;
  endtask

  always @(negedge clock) begin
    int cnt, lower, ng, etag;
    bit eg;
    if (reset && chk_en) begin
      cnt = hist.size() - spec_pos;
      check("free_avail", free_avail, (cnt < N_WAY) ? cnt : N_WAY);
      lower = 0;
      ng    = 0;
      for (int k = 0; k < N_WAY; k++) begin
        eg   = 1'b0;
        etag = 0;
        if (alloc_req[k]) begin
          if (!branch_haz && lower < cnt) begin
            eg   = 1'b1;
            etag = hist[spec_pos + lower];
            ng++;
            owned.push_back(etag);
          end
          lower++;
        end
        check("alloc_grant", alloc_grant[k], eg);
        check("alloc_tag", alloc_tag[k*TAG_W +: TAG_W], etag);
      end
      for (int i = 0; i < N_WAY; i++) begin
        if (retire_valid[i] && retire_told[i*TAG_W +: TAG_W] != 0)
          hist.push_back(int'(retire_told[i*TAG_W +: TAG_W]));
        if (retire_valid[i] && retire_tag[i*TAG_W +: TAG_W] != 0) arch_pos++;
      end
      spec_pos = branch_haz ? arch_pos : spec_pos + ng;
    end
  end

  task automatic drive(input logic [1:0] req, input logic [1:0] rv, input int t0, input int o0,
                       input int t1, input int o1, input bit bh);
    @(posedge clock);
    #1;
    alloc_req    = req;
    retire_valid = rv;
    retire_tag   = {t1[TAG_W-1:0], t0[TAG_W-1:0]};
    retire_told  = {o1[TAG_W-1:0], o0[TAG_W-1:0]};
    branch_haz   = bh;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset        = 1'b0;
    alloc_req    = '0;
    retire_valid = '0;
    retire_tag   = '0;
    retire_told  = '0;
    branch_haz   = 1'b0;
    model_reset();
    #1;
    check("reset_free_avail", free_avail, 2);
    check("reset_grant", alloc_grant, 0);
    check("reset_tag", alloc_tag, 0);
`ifdef FREELIST_ERR_EN
    check("reset_error", error, 0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1;
    logic [1:0] rv;
    model_reset();
    chk_en = 1'b1;
    do_reset();

    // First pops come from the reset-loaded tags 32, 33, ...
    drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    check("first_grant", alloc_grant, 2'b11);
    check("first_tag0", alloc_tag[5:0], 32);
    check("first_tag1", alloc_tag[11:6], 33);
    drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    check("second_tag0", alloc_tag[5:0], 34);
    check("second_tag1", alloc_tag[11:6], 35);

    // Drain to empty.
    repeat (14) drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    check("empty_grant", alloc_grant, 0);
    check("empty_tag", alloc_tag, 0);
    check("empty_avail", free_avail, 0);
    // Push 5: not poppable in the same cycle.
    drive(2'b11, 2'b01, 32, 5, 0, 0, 1'b0);
    check("no_bypass_grant", alloc_grant, 0);
    drive(2'b01, 2'b00, 0, 0, 0, 0, 1'b0);
    check("refill_avail", free_avail, 1);
    check("refill_grant", alloc_grant, 2'b01);
    check("refill_tag", alloc_tag[5:0], 5);

    // count==1 with two requesters.
    drive(2'b00, 2'b01, 33, 6, 0, 0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    check("cnt1_grant", alloc_grant, 2'b01);
    check("cnt1_tag0", alloc_tag[5:0], 6);
    check("cnt1_tag1", alloc_tag[11:6], 0);

    // Flush: retire 32..39, allocate 40..42, then retire 40 with flush.
    do_reset();
    repeat (4) drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    for (int j = 0; j < 4; j++) drive(2'b00, 2'b11, 32 + 2 * j, 0, 33 + 2 * j, 0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    check("pre_flush_tag0", alloc_tag[5:0], 40);
    drive(2'b01, 2'b00, 0, 0, 0, 0, 1'b0);
    check("pre_flush_tag42", alloc_tag[5:0], 42);
    drive(2'b11, 2'b01, 40, 3, 0, 0, 1'b1);
    check("flush_grant", alloc_grant, 0);
    drive(2'b01, 2'b00, 0, 0, 0, 0, 1'b0);
    check("post_flush_tag", alloc_tag[5:0], 41);
    drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
    check("post_flush_tag0", alloc_tag[5:0], 42);
    check("post_flush_tag1", alloc_tag[11:6], 43);

    // Sustained traffic: free tags are recycled so pointers wrap several times.
    do_reset();
    for (int c = 0; c < 200; c++) begin
      n  = $urandom_range(0, 2);
      if (n > owned.size()) n = owned.size();
      rv = 2'b00;
      t0 = 0;
      t1 = 0;
      if (n >= 1) begin rv[0] = 1'b1; t0 = owned.pop_front(); end
      if (n >= 2) begin rv[1] = 1'b1; t1 = owned.pop_front(); end
      drive(2'($urandom_range(0, 3)), rv, t0, t0, t1, t1, 1'b0);
    end
    idle();

`ifdef FREELIST_ERR_EN
    do_reset();
    drive(2'b00, 2'b01, 0, 7, 0, 0, 1'b0);
    check("err_before_edge", error, 0);
    idle();
    check("err_set", error, 1);
    repeat (3) idle();
    check("err_sticky", error, 1);
    do_reset();
    idle();
    check("err_cleared", error, 0);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename/dispatch stage, directly downstream of the ROB retire port. Circular FIFO of free physical tags: dispatch pops up to `N_WAY` tags per cycle for new destinations, ROB retirement pushes each retired instruction's `tag_old` back, and a taken-branch flush (`branch_haz`) rewinds the pop pointer to the architectural (retired) position. This recovers every tag allocated by squashed instructions in one cycle.

## Interface
- `N_WAY`, 2: dispatch/retire width.
- `N_PHYS`, 64: physical registers. Power of two.
- `N_ARCH`, 32: architectural registers. Tags 0..N_ARCH-1 are mapped at reset.
- `TAG_W`, $clog2(N_PHYS): tag width. Equals `CDB_BITS`.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `alloc_req` in N_WAY: per-slot request for a new destination tag.
- `alloc_tag` out N_WAY×TAG_W: granted tag per slot. 0 when not granted.
- `alloc_grant` out N_WAY: per-slot grant.
- `free_avail` out $clog2(N_WAY)+1: min(count, N_WAY), taken from registered state.
- `retire_valid` in N_WAY: ROB retire strobes.
- `retire_tag` in N_WAY×TAG_W: retired destination tag. 0 means no destination.
- `retire_told` in N_WAY×TAG_W: previous mapping to free. 0 means nothing to free.
- `branch_haz` in 1: flush; rewind to the architectural state.
- `error` out 1: only with `FREELIST_ERR_EN`.

## Operation
- Storage: `N_PHYS` entries of TAG_W.
- Pointers, TAG_W+1 wide, with a wrap bit:
  - `head`: speculative pop pointer.
  - `tail`: push pointer.
  - `arch_head`: retired pop pointer.
- `count = tail - head` (TAG_W+1 bit modular arithmetic).
- Reset state:
  - entries 0..N_PHYS-N_ARCH-1 hold tags N_ARCH..N_PHYS-1;
  - head = arch_head = 0, tail = N_PHYS-N_ARCH;
  - all outputs 0 except free_avail = min(N_PHYS-N_ARCH, N_WAY).
- Allocate (combinational):
  - Requesting slots are served in ascending slot index, each taking the next entry from head.
  - Slot k is granted iff alloc_req[k], the number of lower requesting slots is < count, and !branch_haz.
  - Grants are in-order: if slot k is denied for capacity, every higher requesting slot is also denied.
  - head advances by the number of grants.
- Retire, in slot order:
  - For each retire_valid[i] with retire_told[i]≠0, write retire_told[i] at tail and tail += 1.
  - For each retire_valid[i] with retire_tag[i]≠0, arch_head += 1.
- Flush (branch_haz=1):
  - All grants forced 0.
  - Retire updates for the same cycle are applied first.
  - Then head ← the updated arch_head.
- Pushes write into slots never in the live region; count never exceeds N_PHYS-N_ARCH in legal operation.
- Wrap-around: pointer low bits index the array; the wrap bit distinguishes full from empty.

## Timing
- Allocation is zero-latency: alloc_tag/alloc_grant are combinational from registered head/count and the current alloc_req.
- free_avail is registered-state only and does not depend on the same cycle's inputs.
- Tags pushed at cycle t become poppable at t+1. There is no same-cycle push→pop bypass.
- Flush at cycle t: head is rewound at the edge ending t, and the first post-flush grant is possible at t+1.
- Simultaneous pop and push in the same cycle: count_next = count - grants + pushes.
- Asserting reset mid-operation: all state returns to reset values immediately, regardless of clock. Deassertion is synchronised externally.

## Configuration
- `FREELIST_ERR_EN` defined: adds the `error` port, a sticky flag cleared only by reset. It sets on any of:
  - push when count==N_PHYS-N_ARCH (overflow);
  - arch_head advancing past tail;
  - a pushed tag ≥ N_PHYS.
- Undefined: no `error` port, no check logic. Functional behaviour is otherwise identical.

## Test plan
- Reset (reset=0 then 1) -> free_avail=2; alloc_req=2'b11 -> alloc_tag={33,32}, grants=2'b11; next cycle tags {35,34}.
- 32 allocations with no retires -> count=0, alloc_req=2'b11 -> grant=0, tags 0, free_avail=0; one retire with told=5 -> next cycle alloc_req=2'b01 grants tag 5.
- count=1, alloc_req=2'b11 -> only slot 0 granted; slot 1 alloc_grant=0, alloc_tag[1]=0.
- Allocate 40, 41, 42; retire one instruction (tag=40, told=3); branch_haz=1 in the same cycle with alloc_req=2'b11 -> no grants; next cycle the pop order restarts at 41.
- Run 200 cycles of pops and pushes so pointers wrap twice -> tag order preserved across index N_PHYS-1→0; free_avail tracks the reference count exactly.
- With FREELIST_ERR_EN, from reset push told=7 without prior allocation -> error=1 the next cycle and stays high until reset.
